mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Load/store sequencer between the RV32I core's memory stage and the word-organised data memory (data_memory_face.cpu fields).
- Accepts one byte-addressed request of any RV32I width and issues one or two aligned word accesses with byte enables.
- Splits word-crossing accesses into two accesses, aligns store data, and extracts and sign/zero-extends load data.

Parameters:
ALLOW_MISALIGNED, 1, 1 = split word-crossing accesses; 0 = report them as errors with no memory access

Ports:
clk  in  1  single system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_write  in  1  1 = store, 0 = load
req_size  in  3  funct3 width code (BYTE/BYTE_U/HALF/HALF_U/WORD)
req_addr  in  32  byte address
req_wdata  in  32  store data, LSB-justified
resp_valid  out  1  one-cycle completion pulse
resp_err  out  1  illegal size, or misaligned with ALLOW_MISALIGNED=0
resp_rdata  out  32  load result; valid only while resp_valid is high and the request was a load
mem_addr  out  32  Addr_out, always word-aligned ([1:0]=0)
mem_we  out  4  MemWriteEnable byte mask
mem_wdata  out  32  Data_out
mem_rdata  in  32  Data_in

Behaviour:
- Reset (asynchronous, immediate): state IDLE, req_ready=1, resp_valid=0, resp_err=0, mem_we=0, mem_addr=0, mem_wdata=0, internal regs 0. Reset during any state aborts the access with no response; any second half not yet issued is never issued.
- Memory contract:
  - A write commits at the clock edge ending a cycle with mem_we≠0.
  - Read data for the address driven in cycle N appears on mem_rdata in cycle N+1.
- Handshake:
  - req_ready=1 only in IDLE; a request is accepted on req_valid&&req_ready and latched.
  - Inputs are ignored while not in IDLE.
- State machine: IDLE, ACC0, ACC1, DONE.
  - IDLE -> DONE if the request is illegal (size 011/110/111, or crossing with ALLOW_MISALIGNED=0). resp_err=1 and no memory cycle occurs.
  - IDLE -> ACC0 otherwise.
  - ACC0 -> ACC1 if crossing, else DONE.
  - ACC1 -> DONE.
  - DONE -> IDLE. resp_valid=1 for exactly this one cycle.
- Offset/mask arithmetic (off=req_addr[1:0]):
  - Base mask: BYTE 0001, HALF 0011, WORD 1111. mask8 = base << off (8 bits).
  - crossing = (mask8[7:4] != 0).
  - Store data: d64 = {32'b0, wdata} << (8*off).
- Outputs per state:
  - ACC0: mem_addr = {addr[31:2],2'b00}; mem_we = store ? mask8[3:0] : 0; mem_wdata = d64[31:0].
  - ACC1: mem_addr = ACC0 address + 4 (wraps modulo 2^32); mem_we = store ? mask8[7:4] : 0; mem_wdata = d64[63:32].
  - IDLE/DONE: mem_we=0; mem_addr and mem_wdata hold their last value.
- Load data path:
  - In ACC1, mem_rdata (the low word) is captured into lo_q.
  - In DONE, w64 = crossing ? {mem_rdata, lo_q} : {32'b0, mem_rdata}; raw = w64 >> (8*off).
  - BYTE sign-extends raw[7:0]; BYTE_U zero-extends it. HALF/HALF_U do the same on raw[15:0]. WORD passes raw[31:0].
  - resp_rdata is combinational in DONE and 0 at all other times.
- Latency from the accept edge T: aligned access resp_valid at T+2; crossing access at T+3; error at T+1. Back-to-back throughput is one request per 3 (aligned) or 4 (crossing) cycles.
- Store responses carry resp_rdata=0.

Decomposition:
- Shared package mem_ctrl_pkg holds:
  - the state enum;
  - base-mask constants per width;
  - a size-legality function, keyed on the BYTE/HALF/WORD codes from the shared RV32I header.
- One natural sub-module, mem_load_align: combinational; inputs w64, off, size; output resp_rdata.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF -> T+1: mem_addr 0x100, mem_we 1111, mem_wdata 0xDEADBEEF; T+2: resp_valid=1, resp_err=0.
- SB addr 0x103, data 0x000000AB -> mem_addr 0x100, mem_we 1000, mem_wdata 0xAB000000; single access.
- Word at 0x100 = 0x12803456: LB addr 0x102 -> resp_rdata 0xFFFFFF80 at T+2; LBU addr 0x102 -> 0x00000080.
- mem[0xFC]=0xAABBCCDD, mem[0x100]=0x11223344: LW addr 0xFE -> T+1 mem_addr 0xFC, T+2 mem_addr 0x100, T+3 resp_rdata 0x3344AABB. With ALLOW_MISALIGNED=0 -> resp_err=1 at T+1 and mem_we stays 0 throughout.
- SH addr 0xFF, data 0x0000CAFE:
  - T+1: mem_addr 0xFC, mem_we 1000, mem_wdata 0xFE000000.
  - T+2: mem_addr 0x100, mem_we 0001, mem_wdata 0x000000CA.
  - Same request with rst_n pulsed low during ACC0 -> mem_we drops to 0 immediately, no ACC1, no resp_valid, req_ready=1 after release.
- req_size 3'b011 -> resp_valid=1 and resp_err=1 at T+1, no memory cycle; a req_valid held during busy states is not accepted until IDLE.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the load/store sequencer: FSM states, RV32I
// funct3 width codes, per-width base byte masks and a size-legality check.
package mem_ctrl_pkg;

    localparam int unsigned XLEN = 32;

    // RV32I load/store funct3 width codes
    localparam logic [2:0] SIZE_BYTE   = 3'b000;
    localparam logic [2:0] SIZE_HALF   = 3'b001;
    localparam logic [2:0] SIZE_WORD   = 3'b010;
    localparam logic [2:0] SIZE_BYTE_U = 3'b100;
    localparam logic [2:0] SIZE_HALF_U = 3'b101;

    // Byte-enable masks for an access at offset 0
    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC0,
        ST_ACC1,
        ST_DONE
    } state_t;

    function automatic logic size_legal(input logic [2:0] size);
        case (size)
            SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_BYTE_U, SIZE_HALF_U: size_legal = 1'b1;
            default:                                                   size_legal = 1'b0;
        endcase
    endfunction

    // Unsigned variants share the signed variant's width via the low two bits
    function automatic logic [3:0] base_mask(input logic [2:0] size);
        case (size[1:0])
            2'b00:   base_mask = MASK_BYTE;
            2'b01:   base_mask = MASK_HALF;
            2'b10:   base_mask = MASK_WORD;
            default: base_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data extraction: shifts the (possibly two-word) read data down by the
// byte offset and sign/zero-extends it to the requested width.
//   w64        : {high word, low word} as returned by memory
//   off        : byte offset of the request within the first word
//   size       : funct3 width code
//   resp_rdata : extended load result (combinational)
module mem_load_align
    import mem_ctrl_pkg::*;
(
    input  logic [2*XLEN-1:0] w64,
    input  logic [1:0]        off,
    input  logic [2:0]        size,
    output logic [XLEN-1:0]   resp_rdata
);

    logic [XLEN-1:0] raw;

    always_comb begin
        raw        = XLEN'(w64 >> {off, 3'b000});
        resp_rdata = '0;
        case (size)
            SIZE_BYTE:   resp_rdata = {{24{raw[7]}}, raw[7:0]};
            SIZE_BYTE_U: resp_rdata = {24'h0, raw[7:0]};
            SIZE_HALF:   resp_rdata = {{16{raw[15]}}, raw[15:0]};
            SIZE_HALF_U: resp_rdata = {16'h0, raw[15:0]};
            SIZE_WORD:   resp_rdata = raw;
            default:     resp_rdata = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the core memory stage and a word-organised
// data memory. Takes one byte-addressed request, issues one or two aligned
// word accesses with byte enables, and returns an aligned/extended result.
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : request handshake (ready only when idle)
//   req_write/size/addr/wdata : request payload
//   resp_valid/err/rdata : one-cycle completion pulse, error flag, load data
//   mem_addr/we/wdata    : word-aligned memory address, byte enables, data
//   mem_rdata            : read data, one cycle after the address
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      req_size,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic            resp_err,
    output logic [XLEN-1:0] resp_rdata,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_we,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    state_t            state_q, state_d;

    logic [7:0]        mask8_c;
    logic [2*XLEN-1:0] d64_c;
    logic              cross_c, illegal_c, accept_c;

    logic              write_q, cross_q;
    logic [2:0]        size_q;
    logic [1:0]        off_q;
    logic [3:0]        hi_we_q;
    logic [XLEN-1:0]   hi_wdata_q, lo_q;

    logic [XLEN-1:0]   addr_d, wdata_d;
    logic [3:0]        we_d;
    logic              err_d;

    logic [2*XLEN-1:0] w64_c;
    logic [XLEN-1:0]   align_rdata_c;

    // Request decode: byte lanes over two words and store data placement
    always_comb begin
        mask8_c   = {4'b0000, base_mask(req_size)} << req_addr[1:0];
        cross_c   = |mask8_c[7:4];
        d64_c     = {32'h0, req_wdata} << {req_addr[1:0], 3'b000};
        illegal_c = !size_legal(req_size) || (cross_c && !ALLOW_MISALIGNED);
        accept_c  = req_valid && req_ready;
    end

    // Next state and next values of the registered memory-side outputs
    always_comb begin
        state_d = state_q;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        we_d    = 4'b0000;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (illegal_c) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_ACC0;
                        addr_d  = {req_addr[31:2], 2'b00};
                        we_d    = req_write ? mask8_c[3:0] : 4'b0000;
                        wdata_d = d64_c[31:0];
                    end
                end
            end
            ST_ACC0: begin
                if (cross_q) begin
                    state_d = ST_ACC1;
                    addr_d  = mem_addr + 32'd4;
                    we_d    = hi_we_q;
                    wdata_d = hi_wdata_q;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_ACC1: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            mem_addr   <= '0;
            mem_we     <= 4'b0000;
            mem_wdata  <= '0;
        end else begin
            state_q    <= state_d;
            req_ready  <= (state_d == ST_IDLE);
            resp_valid <= (state_d == ST_DONE);
            resp_err   <= err_d;
            mem_addr   <= addr_d;
            mem_we     <= we_d;
            mem_wdata  <= wdata_d;
        end
    end

    // Latched request and the low word of a split load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q    <= 1'b0;
            cross_q    <= 1'b0;
            size_q     <= 3'b000;
            off_q      <= 2'b00;
            hi_we_q    <= 4'b0000;
            hi_wdata_q <= '0;
            lo_q       <= '0;
        end else begin
            if (accept_c) begin
                write_q    <= req_write;
                cross_q    <= cross_c;
                size_q     <= req_size;
                off_q      <= req_addr[1:0];
                hi_we_q    <= req_write ? mask8_c[7:4] : 4'b0000;
                hi_wdata_q <= d64_c[63:32];
            end
            if (state_q == ST_ACC1) begin
                lo_q <= mem_rdata;
            end
        end
    end

    // In DONE, mem_rdata holds the last word read (high word when split)
    assign w64_c = cross_q ? {mem_rdata, lo_q} : {32'h0, mem_rdata};

    mem_load_align u_load_align (
        .w64        (w64_c),
        .off        (off_q),
        .size       (size_q),
        .resp_rdata (align_rdata_c)
    );

    assign resp_rdata = (state_q == ST_DONE && !write_q && !resp_err) ? align_rdata_c : '0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a byte-lane word memory model.
// A second instance with ALLOW_MISALIGNED=0 covers the error path.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_valid_na, req_write;
    logic [2:0]  req_size;
    logic [31:0] req_addr, req_wdata;

    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_we;

    logic        req_ready_na, resp_valid_na, resp_err_na;
    logic [31:0] resp_rdata_na, mem_addr_na, mem_wdata_na;
    logic [3:0]  mem_we_na;

    logic [31:0] mem [0:255];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_access_ctrl #(.ALLOW_MISALIGNED(1'b0)) dut_na (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_na), .req_ready(req_ready_na),
        .req_write(req_write), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid_na), .resp_err(resp_err_na), .resp_rdata(resp_rdata_na),
        .mem_addr(mem_addr_na), .mem_we(mem_we_na), .mem_wdata(mem_wdata_na),
        .mem_rdata(32'h0)
    );

    // Word memory: byte-lane writes at the edge, read data one cycle later
    always @(posedge clk) begin
        if (mem_we[0]) mem[mem_addr[9:2]][7:0]   <= mem_wdata[7:0];
        if (mem_we[1]) mem[mem_addr[9:2]][15:8]  <= mem_wdata[15:8];
        if (mem_we[2]) mem[mem_addr[9:2]][23:16] <= mem_wdata[23:16];
        if (mem_we[3]) mem[mem_addr[9:2]][31:24] <= mem_wdata[31:24];
        mem_rdata <= mem[mem_addr[9:2]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for one cycle; returns #1 after the accept edge
    task automatic issue(input bit na, input bit wr, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req_write = wr;
        req_size  = sz;
        req_addr  = a;
        req_wdata = d;
        if (na) req_valid_na = 1'b1;
        else    req_valid    = 1'b1;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_valid_na = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b exp 1", req_ready); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", resp_valid); end
        n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b exp 0", resp_err); end
        n_checks++; if (mem_we !== 4'b0000) begin n_fail++; $display("FAIL rst_we: got %b exp 0000", mem_we); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h exp 0", mem_addr); end
        n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata: got %h exp 0", mem_wdata); end
        n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h exp 0", resp_rdata); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_store_word();
        issue(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        n_checks++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL sw_addr: got %h exp 100", mem_addr); end
        n_checks++; if (mem_we !== 4'b1111) begin n_fail++; $display("FAIL sw_we: got %b exp 1111", mem_we); end
        n_checks++; if (mem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_wdata: got %h exp deadbeef", mem_wdata); end
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL sw_ready_busy: got %b exp 0", req_ready); end
        step();
        n_checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin n_fail++; $display("FAIL sw_resp: got v=%b e=%b exp v=1 e=0", resp_valid, resp_err); end
        n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL sw_rdata: got %h exp 0", resp_rdata); end
        n_checks++; if (mem[64] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_mem: got %h exp deadbeef", mem[64]); end
        step();
        n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL sw_idle: got v=%b r=%b exp v=0 r=1", resp_valid, req_ready); end
    endtask

    task automatic test_store_byte();
        issue(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000AB);
        n_checks++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL sb_addr: got %h exp 100", mem_addr); end
        n_checks++; if (mem_we !== 4'b1000) begin n_fail++; $display("FAIL sb_we: got %b exp 1000", mem_we); end
        n_checks++; if (mem_wdata !== 32'hAB000000) begin n_fail++; $display("FAIL sb_wdata: got %h exp ab000000", mem_wdata); end
        step();
        n_checks++; if (resp_valid !== 1'b1 || mem_we !== 4'b0000) begin n_fail++; $display("FAIL sb_single: got v=%b we=%b exp v=1 we=0000", resp_valid, mem_we); end
        n_checks++; if (mem[64] !== 32'hABADBEEF) begin n_fail++; $display("FAIL sb_mem: got %h exp abadbeef", mem[64]); end
        step();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req_write = 1'b1; req_size = 3'b010; req_addr = 32'h100; req_wdata = 32'h12803456;
        req_valid = 1'b1;
        step();
        n_checks++; if (mem_we !== 4'b1111 || req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_acc0: got we=%b r=%b exp we=1111 r=0", mem_we, req_ready); end
        step();
        n_checks++; if (resp_valid !== 1'b1 || mem_we !== 4'b0000 || req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_done: got v=%b we=%b r=%b exp v=1 we=0000 r=0", resp_valid, mem_we, req_ready); end
        step();
        n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_we !== 4'b0000) begin n_fail++; $display("FAIL b2b_idle: got r=%b v=%b we=%b exp r=1 v=0 we=0000", req_ready, resp_valid, mem_we); end
        req_addr = 32'h0FC; req_wdata = 32'hAABBCCDD;
        step();
        req_valid = 1'b0;
        n_checks++; if (mem_addr !== 32'hFC || mem_wdata !== 32'hAABBCCDD || mem_we !== 4'b1111) begin n_fail++; $display("FAIL b2b_second: got a=%h d=%h we=%b exp a=fc d=aabbccdd we=1111", mem_addr, mem_wdata, mem_we); end
        step();
        step();
        n_checks++; if (mem[64] !== 32'h12803456 || mem[63] !== 32'hAABBCCDD) begin n_fail++; $display("FAIL b2b_mem: got %h %h exp 12803456 aabbccdd", mem[64], mem[63]); end
    endtask

    task automatic test_load_ext();
        logic [31:0] addrs [4] = '{32'h102, 32'h102, 32'h102, 32'h100};
        logic [2:0]  sizes [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] exps  [4] = '{32'hFFFFFF80, 32'h00000080, 32'h00001280, 32'h00003456};
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 1'b0, sizes[i], addrs[i], 32'h0);
            n_checks++; if (mem_we !== 4'b0000 || mem_addr !== 32'h100) begin n_fail++; $display("FAIL ld%0d_acc: got we=%b a=%h exp we=0000 a=100", i, mem_we, mem_addr); end
            step();
            n_checks++; if (resp_valid !== 1'b1 || resp_rdata !== exps[i]) begin n_fail++; $display("FAIL ld%0d_data: got v=%b d=%h exp v=1 d=%h", i, resp_valid, resp_rdata, exps[i]); end
            step();
            n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL ld%0d_rdata_idle: got %h exp 0", i, resp_rdata); end
        end
    endtask

    task automatic test_misaligned_load();
        issue(1'b0, 1'b1, 3'b010, 32'h100, 32'h11223344);
        step();
        step();
        issue(1'b0, 1'b0, 3'b010, 32'h0FE, 32'h0);
        n_checks++; if (mem_addr !== 32'hFC || mem_we !== 4'b0000) begin n_fail++; $display("FAIL lwx_acc0: got a=%h we=%b exp a=fc we=0000", mem_addr, mem_we); end
        step();
        n_checks++; if (mem_addr !== 32'h100 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL lwx_acc1: got a=%h v=%b exp a=100 v=0", mem_addr, resp_valid); end
        step();
        n_checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h3344AABB) begin n_fail++; $display("FAIL lwx_data: got v=%b e=%b d=%h exp v=1 e=0 d=3344aabb", resp_valid, resp_err, resp_rdata); end
        step();
    endtask

    task automatic test_misaligned_store();
        issue(1'b0, 1'b1, 3'b001, 32'h0FF, 32'h0000CAFE);
        n_checks++; if (mem_addr !== 32'hFC || mem_we !== 4'b1000 || mem_wdata !== 32'hFE000000) begin n_fail++; $display("FAIL shx_acc0: got a=%h we=%b d=%h exp a=fc we=1000 d=fe000000", mem_addr, mem_we, mem_wdata); end
        step();
        n_checks++; if (mem_addr !== 32'h100 || mem_we !== 4'b0001 || mem_wdata !== 32'h000000CA) begin n_fail++; $display("FAIL shx_acc1: got a=%h we=%b d=%h exp a=100 we=0001 d=000000ca", mem_addr, mem_we, mem_wdata); end
        step();
        n_checks++; if (resp_valid !== 1'b1 || mem[63] !== 32'hFEBBCCDD || mem[64] !== 32'h112233CA) begin n_fail++; $display("FAIL shx_done: got v=%b %h %h exp v=1 febbccdd 112233ca", resp_valid, mem[63], mem[64]); end
        step();
        issue(1'b0, 1'b0, 3'b001, 32'h0FF, 32'h0);
        step();
        step();
        n_checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hFFFFCAFE) begin n_fail++; $display("FAIL lhx_data: got v=%b d=%h exp v=1 d=ffffcafe", resp_valid, resp_rdata); end
        step();
    endtask

    task automatic test_no_misaligned();
        issue(1'b1, 1'b0, 3'b010, 32'h0FE, 32'h0);
        n_checks++; if (resp_valid_na !== 1'b1 || resp_err_na !== 1'b1) begin n_fail++; $display("FAIL na_err: got v=%b e=%b exp v=1 e=1", resp_valid_na, resp_err_na); end
        n_checks++; if (mem_we_na !== 4'b0000 || resp_rdata_na !== 32'h0) begin n_fail++; $display("FAIL na_nomem: got we=%b d=%h exp we=0000 d=0", mem_we_na, resp_rdata_na); end
        step();
        n_checks++; if (resp_valid_na !== 1'b0 || req_ready_na !== 1'b1 || mem_we_na !== 4'b0000) begin n_fail++; $display("FAIL na_idle: got v=%b r=%b we=%b exp v=0 r=1 we=0000", resp_valid_na, req_ready_na, mem_we_na); end
        n_checks++; if (mem_addr_na !== 32'h0 || mem_wdata_na !== 32'h0) begin n_fail++; $display("FAIL na_bus: got a=%h d=%h exp 0 0", mem_addr_na, mem_wdata_na); end
    endtask

    task automatic test_reset_abort();
        issue(1'b0, 1'b1, 3'b001, 32'h0FF, 32'h00001234);
        n_checks++; if (mem_we !== 4'b1000) begin n_fail++; $display("FAIL abort_acc0: got we=%b exp 1000", mem_we); end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (mem_we !== 4'b0000 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL abort_now: got we=%b r=%b v=%b exp we=0000 r=1 v=0", mem_we, req_ready, resp_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (resp_valid !== 1'b0 || mem_we !== 4'b0000) begin n_fail++; $display("FAIL abort_quiet%0d: got v=%b we=%b exp v=0 we=0000", i, resp_valid, mem_we); end
        end
        n_checks++; if (req_ready !== 1'b1 || mem[63] !== 32'hFEBBCCDD || mem[64] !== 32'h112233CA) begin n_fail++; $display("FAIL abort_mem: got r=%b %h %h exp r=1 febbccdd 112233ca", req_ready, mem[63], mem[64]); end
    endtask

    task automatic test_illegal_size();
        issue(1'b0, 1'b0, 3'b011, 32'h100, 32'h0);
        n_checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || mem_we !== 4'b0000) begin n_fail++; $display("FAIL ill_resp: got v=%b e=%b we=%b exp v=1 e=1 we=0000", resp_valid, resp_err, mem_we); end
        n_checks++; if (resp_rdata !== 32'h0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL ill_misc: got d=%h r=%b exp d=0 r=0", resp_rdata, req_ready); end
        step();
        n_checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL ill_idle: got v=%b e=%b r=%b exp v=0 e=0 r=1", resp_valid, resp_err, req_ready); end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_valid_na = 1'b0; req_write = 1'b0;
        req_size = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        test_reset();
        test_store_word();
        test_store_byte();
        test_back_to_back();
        test_load_ext();
        test_misaligned_load();
        test_misaligned_store();
        test_no_misaligned();
        test_reset_abort();
        test_illegal_size();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
